// File: rtl/prog_loader.sv
// prog_loader: length-prefixed byte stream -> little-endian 32-bit word writes.
// Holds core_rst high until the image is written; optional CHECKSUM_EN adds a trailing sum byte.
// Ports: clk, rst (sync, active-high), in_valid/in_data/in_ready (byte stream),
//   mem_we/mem_addr/mem_wdata (word write), core_rst, done, err (status).
module prog_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR
  } state_t;
  localparam state_t LAST = CHK;
`else
  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, WRITE, DONE, ERR
  } state_t;
  localparam state_t LAST = DONE;
`endif

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state, state_n;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   len;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   idx_next;
  logic [15:0]       len_full;
  logic              take;
`ifdef CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign take     = in_valid & in_ready;
  assign len_full = {in_data, len_lo};
  assign idx_next = word_idx + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= HDR0;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HDR0: if (take) state_n = HDR1;
      HDR1: begin
        if (take) begin
          if (len_full == 16'd0)
            state_n = LAST;
          else if ({1'b0, len_full} > DEPTH)
            state_n = ERR;
          else
            state_n = DATA;
        end
      end
      DATA:  if (take && byte_cnt == 2'd3) state_n = WRITE;
      WRITE: state_n = (idx_next == len) ? LAST : DATA;
`ifdef CHECKSUM_EN
      CHK: begin
        if (take) state_n = (in_data == csum) ? DONE : ERR;
      end
`endif
      DONE:    state_n = DONE;
      ERR:     state_n = ERR;
      default: state_n = HDR0;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    core_rst = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    mem_addr = word_idx[ADDR_W-1:0];
    unique case (state)
      HDR0, HDR1, DATA: in_ready = !rst;
`ifdef CHECKSUM_EN
      CHK:   in_ready = !rst;
`endif
      WRITE: mem_we = 1'b1;
      DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      ERR:     err = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo    <= '0;
      len       <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      mem_wdata <= '0;
`ifdef CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (state == HDR0 && take)
        len_lo <= in_data;
      if (state == HDR1 && take)
        len <= len_full[ADDR_W:0];
      if (state == DATA && take) begin
        mem_wdata[{byte_cnt, 3'b000} +: 8] <= in_data;
        byte_cnt <= byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
        csum <= csum + in_data;
`endif
      end
      if (state == WRITE)
        word_idx <= idx_next;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random-image scoreboard bench for prog_loader.
// Expected writes are queued at stimulus time; a negedge monitor pops and compares.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  prog_loader #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[0:4095];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          writes = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      writes++;
      chk("ready_in_write", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %0d data %h want none",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("ready_in_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
  endtask

  // stop >= 0 aborts after that many data bytes; bad corrupts the checksum.
  task automatic load(input int len, input bit gaps, input int stop,
                      input bit bad);
    int         sent = 0;
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    send(8'(len), gaps);
    send(8'(len >> 8), gaps);
    if (len > 4096) begin
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_core_rst", 32'(core_rst), 32'd1);
      chk("ovf_ready", 32'(in_ready), 32'd0);
      chk("ovf_done", 32'(done), 32'd0);
      return;
    end
`ifndef CHECKSUM_EN
    if (len == 0) chk("len0_done_now", 32'(done), 32'd1);
`endif
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (sent == stop) return;
        b = 8'(img[i] >> (8 * j));
        sum = sum + b;
        send(b, gaps);
        sent++;
        if (j == 3) exp_q.push_back('{12'(i), img[i]});
      end
    end
    if (len > 0) begin
      chk("we_after_last_byte", 32'(mem_we), 32'd1);
      @(posedge clk);
      #1;
    end
`ifdef CHECKSUM_EN
    send(bad ? 8'(sum + 8'd1) : sum, gaps);
`endif
    chk("end_done", 32'(done), 32'(!bad));
    chk("end_err", 32'(err), 32'(bad));
    chk("end_core_rst", 32'(core_rst), 32'(bad));
    chk("end_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic rand_img(input int n);
    for (int i = 0; i < n; i++) img[i] = $urandom;
  endtask

  task automatic idle_valid(input int n);
    @(negedge clk);
    in_valid = 1'b1;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int w0;
    repeat (2) @(negedge clk);
    do_reset();

    img[0] = 32'h00000513;
    img[1] = 32'h00150593;
    w0 = writes;
    load(2, 1'b0, -1, 1'b0);
    idle_valid(3);
    chk("t1_pulses", 32'(writes - w0), 32'd2);
    chk("t1_done_sticky", 32'(done), 32'd1);

    do_reset();
    w0 = writes;
    load(0, 1'b0, -1, 1'b0);
    idle_valid(3);
    chk("t2_no_writes", 32'(writes - w0), 32'd0);

    do_reset();
    w0 = writes;
    load(32'h1001, 1'b0, -1, 1'b0);
    idle_valid(3);
    chk("t3_no_writes", 32'(writes - w0), 32'd0);
    chk("t3_err_sticky", 32'(err), 32'd1);

    rand_img(8);
    do_reset();
    load(8, 1'b0, -1, 1'b0);
    do_reset();
    load(8, 1'b1, -1, 1'b0);

    rand_img(8);
    do_reset();
    load(8, 1'b0, 6, 1'b0);
    do_reset();
    rand_img(1);
    load(1, 1'b1, -1, 1'b0);

    rand_img(4096);
    do_reset();
    load(4096, 1'b0, -1, 1'b0);

`ifdef CHECKSUM_EN
    img[0] = 32'h04030201;
    do_reset();
    load(1, 1'b0, -1, 1'b0);
    do_reset();
    load(1, 1'b0, -1, 1'b1);
    do_reset();
    load(0, 1'b0, -1, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
